// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the stall LFSR seed and the byte-select helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } hsize_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // 8-lane byte select for a transfer of the given size at the low address bits.
    function automatic logic [7:0] byte_sel(input logic [1:0] size, input logic [2:0] a);
        logic [7:0] s;
        case (size)
            SZ_BYTE: s = 8'h01 << a;
            SZ_HALF: s = 8'h03 << {a[2:1], 1'b0};
            SZ_WORD: s = 8'h0F << {a[2], 2'b00};
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_bridge_if.sv
// AHB-Lite slave-side bus bundle.
interface ahb_slave_mem_bridge_if #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
);
    logic [ADDR_BITS-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [1:0]           HSIZE;
    logic [DATA_BITS-1:0] HWDATA;
    logic [DATA_BITS-1:0] HRDATA;
    logic                 HREADY;
    logic                 HRESP;

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_stall_lfsr.sv
// Pseudo-random wait-state generator: free-running 16-bit LFSR and a registered stall flag.
module ahb_stall_lfsr
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_enable,
    input  logic [3:0] stall_thresh,
    output logic       stall
);
    logic [15:0] lfsr;
    logic        fb;

    // Fibonacci taps 16,14,13,11 in right-shift form; the sequence is repeatable from the seed.
    assign fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Advance the LFSR every cycle and register the stall decision from its low nibble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr  <= LFSR_SEED;
            stall <= 1'b0;
        end else begin
            lfsr  <= {fb, lfsr[15:1]};
            stall <= stall_enable & (lfsr[3:0] < stall_thresh);
        end
    end
endmodule

// File: rtl/ahb_slave_mem_bridge.sv
// AHB-Lite slave to single-cycle SRAM strobe bridge with injectable stalls, errors and hangs.
module ahb_slave_mem_bridge
    import ahb_pkg::*;
#(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32   // 32 or 64 only
) (
    input  logic                   clk,
    input  logic                   reset,
    ahb_slave_mem_bridge_if.slave  bus,
    input  logic                   stall_enable,
    input  logic [3:0]             stall_thresh,
    input  logic [ADDR_BITS-1:0]   hresp_addr,
    input  logic [ADDR_BITS-1:0]   timeout_addr,
    output logic                   RD,
    output logic [ADDR_BITS-1:0]   ADDR_RD,
    output logic                   WR,
    output logic [ADDR_BITS-1:0]   ADDR_WR,
    output logic [DATA_BITS-1:0]   DIN,
    output logic [DATA_BITS/8-1:0] BSEL,
    input  logic [DATA_BITS-1:0]   DOUT
);
    logic       stall;
    logic       timeout_stall;
    logic       hresp_q;
    logic       data_phase;
    logic       wr_pre;
    logic       wr_pre_d;
    logic [1:0] hsize_d;
    logic       hready;
    logic       act;
    logic       any_tr;
    logic [7:0] sel8;

    ahb_stall_lfsr u_stall (
        .clk          (clk),
        .reset        (reset),
        .stall_enable (stall_enable),
        .stall_thresh (stall_thresh),
        .stall        (stall)
    );

    assign act    = bus.HTRANS[1];
    assign any_tr = |bus.HTRANS;

    // BUSY always waits; otherwise a hang or a random stall holds the bus.
    always_comb begin
        hready = ~timeout_stall & ~stall;
        if (bus.HTRANS == TR_BUSY) hready = 1'b0;
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp_q;

    // Reads are issued straight from the address phase; memory answers one cycle later.
    assign RD         = ~bus.HWRITE & act & hready;
    assign ADDR_RD    = RD ? bus.HADDR : '0;
    assign bus.HRDATA = (hready & data_phase) ? DOUT : '0;

    // Writes are captured in the address phase and strobed in the data phase with HWDATA.
    assign wr_pre = bus.HWRITE & act;
    assign WR     = wr_pre_d & hready;
    assign DIN    = bus.HWDATA;

    assign sel8 = byte_sel(hsize_d, ADDR_WR[2:0]);

    generate
        if (DATA_BITS == 64) begin : g_bsel64
            assign BSEL = sel8;
        end else begin : g_bsel32
            assign BSEL = ADDR_WR[2] ? sel8[7:4] : sel8[3:0];
        end
    endgenerate

    // Track the read data phase; a new read keeps it open, a completed cycle closes it.
    always_ff @(posedge clk) begin
        if (!reset)      data_phase <= 1'b0;
        else if (RD)     data_phase <= 1'b1;
        else if (hready) data_phase <= 1'b0;
    end

    // Latch write address-phase controls whenever the bus advances.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_pre_d <= 1'b0;
            ADDR_WR  <= '0;
            hsize_d  <= 2'b00;
        end else if (hready) begin
            wr_pre_d <= wr_pre;
            ADDR_WR  <= wr_pre ? bus.HADDR : '0;
            hsize_d  <= bus.HSIZE;
        end
    end

    // Error response for the programmed address, held until the bus advances.
    always_ff @(posedge clk) begin
        if (!reset)                                hresp_q <= 1'b0;
        else if (any_tr && bus.HADDR == hresp_addr) hresp_q <= 1'b1;
        else if (hready)                           hresp_q <= 1'b0;
    end

    // Sticky hang: only released by programming timeout_addr back to zero.
    always_ff @(posedge clk) begin
        if (!reset)                                  timeout_stall <= 1'b0;
        else if (any_tr && bus.HADDR == timeout_addr) timeout_stall <= 1'b1;
        else if (timeout_addr == '0)                 timeout_stall <= 1'b0;
    end
endmodule

// File: tb/tb_ahb_slave_mem_bridge.sv
// Directed bench for the AHB slave memory bridge (32-bit and 64-bit builds side by side).
module tb_ahb_slave_mem_bridge;
    import ahb_pkg::*;

    localparam int AB = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_enable;
    logic [3:0]    stall_thresh;
    logic [AB-1:0] hresp_addr, timeout_addr;
    logic [31:0]   dout;

    logic          rd, wr, rd64, wr64;
    logic [AB-1:0] addr_rd, addr_wr, addr_rd64, addr_wr64;
    logic [31:0]   din;
    logic [63:0]   din64;
    logic [3:0]    bsel;
    logic [7:0]    bsel64;

    int vecs = 0;
    int errs = 0;

    ahb_slave_mem_bridge_if #(.ADDR_BITS(AB), .DATA_BITS(32)) b ();
    ahb_slave_mem_bridge_if #(.ADDR_BITS(AB), .DATA_BITS(64)) b64 ();

    assign b64.HADDR  = b.HADDR;
    assign b64.HTRANS = b.HTRANS;
    assign b64.HWRITE = b.HWRITE;
    assign b64.HSIZE  = b.HSIZE;
    assign b64.HWDATA = {2{b.HWDATA}};

    always #5 clk = ~clk;

    ahb_slave_mem_bridge #(.ADDR_BITS(AB), .DATA_BITS(32)) dut (
        .clk(clk), .reset(reset), .bus(b),
        .stall_enable(stall_enable), .stall_thresh(stall_thresh),
        .hresp_addr(hresp_addr), .timeout_addr(timeout_addr),
        .RD(rd), .ADDR_RD(addr_rd), .WR(wr), .ADDR_WR(addr_wr),
        .DIN(din), .BSEL(bsel), .DOUT(dout)
    );

    ahb_slave_mem_bridge #(.ADDR_BITS(AB), .DATA_BITS(64)) dut64 (
        .clk(clk), .reset(reset), .bus(b64),
        .stall_enable(stall_enable), .stall_thresh(stall_thresh),
        .hresp_addr(hresp_addr), .timeout_addr(timeout_addr),
        .RD(rd64), .ADDR_RD(addr_rd64), .WR(wr64), .ADDR_WR(addr_wr64),
        .DIN(din64), .BSEL(bsel64), .DOUT({2{dout}})
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic w, input logic [AB-1:0] a, input logic [1:0] sz);
        b.HTRANS = tr;
        b.HWRITE = w;
        b.HADDR  = a;
        b.HSIZE  = sz;
        #1;
    endtask

    initial begin
        int lows, bad;
        reset = 1'b0; stall_enable = 1'b0; stall_thresh = 4'd0;
        hresp_addr = 24'hFFFFFF; timeout_addr = '0; dout = '0;
        b.HWDATA = '0;
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        tick(); tick();
        #1;
        chk("rst_hready", b.HREADY, 1);
        chk("rst_hresp", b.HRESP, 0);
        chk("rst_hrdata", b.HRDATA, 0);
        chk("rst_wr", wr, 0);
        chk("rst_addr_wr", addr_wr, 0);
        reset = 1'b1;
        tick();

        // word write
        drive(TR_NONSEQ, 1'b1, 24'h000104, SZ_WORD);
        chk("wr_addr_phase_wr", wr, 0);
        chk("wr_addr_phase_rd", rd, 0);
        tick();
        b.HWDATA = 32'hDEADBEEF;
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("wr_data_wr", wr, 1);
        chk("wr_data_addr", addr_wr, 24'h000104);
        chk("wr_data_bsel", bsel, 4'hF);
        chk("wr_data_din", din, 32'hDEADBEEF);
        tick();
        #1;
        chk("wr_done_wr", wr, 0);

        // byte write 0x003
        drive(TR_NONSEQ, 1'b1, 24'h000003, SZ_BYTE);
        tick();
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("byte3_wr", wr, 1);
        chk("byte3_bsel32", bsel, 4'b1000);
        chk("byte3_bsel64", bsel64, 8'h08);
        tick();

        // half write 0x006
        drive(TR_NONSEQ, 1'b1, 24'h000006, SZ_HALF);
        tick();
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("half6_bsel32", bsel, 4'b1100);
        chk("half6_bsel64", bsel64, 8'hC0);
        tick();

        // byte write 0x005
        drive(TR_NONSEQ, 1'b1, 24'h000005, SZ_BYTE);
        tick();
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("byte5_bsel64", bsel64, 8'h20);
        chk("byte5_bsel32", bsel, 4'h2);
        chk("byte5_wr64", wr64, 1);
        tick();

        // read 0x200
        drive(TR_NONSEQ, 1'b0, 24'h000200, SZ_WORD);
        chk("rd_rd", rd, 1);
        chk("rd_addr", addr_rd, 24'h000200);
        chk("rd_hrdata_early", b.HRDATA, 0);
        tick();
        dout = 32'h12345678;
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("rd_idle_rd", rd, 0);
        chk("rd_idle_addr", addr_rd, 0);
        chk("rd_hrdata", b.HRDATA, 32'h12345678);
        chk("rd_hrdata64", b64.HRDATA, 64'h12345678_12345678);
        tick();
        #1;
        chk("rd_hrdata_clr", b.HRDATA, 0);
        dout = '0;

        // error response
        hresp_addr = 24'h000300;
        drive(TR_NONSEQ, 1'b0, 24'h000300, SZ_WORD);
        chk("err_same_cycle", b.HRESP, 0);
        tick();
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("err_set", b.HRESP, 1);
        tick();
        #1;
        chk("err_clr", b.HRESP, 0);

        // sticky timeout
        timeout_addr = 24'h000400;
        drive(TR_NONSEQ, 1'b0, 24'h000400, SZ_WORD);
        chk("to_first_ready", b.HREADY, 1);
        tick();
        drive(TR_NONSEQ, 1'b1, 24'h000410, SZ_WORD);
        chk("to_hang_ready", b.HREADY, 0);
        chk("to_hang_rd", rd, 0);
        tick();
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("to_hang_wr", wr, 0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b.HREADY === 1'b0) lows++;
        end
        chk("to_hang_20cyc", lows, 20);
        timeout_addr = '0;
        #1;
        chk("to_release_same", b.HREADY, 0);
        tick();
        #1;
        chk("to_released", b.HREADY, 1);

        // BUSY
        drive(TR_BUSY, 1'b0, 24'h000500, SZ_WORD);
        chk("busy_ready", b.HREADY, 0);
        chk("busy_rd", rd, 0);
        tick();
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("busy_exit_ready", b.HREADY, 1);
        tick();

        // random stalls
        stall_enable = 1'b1; stall_thresh = 4'd8;
        lows = 0; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            drive(TR_NONSEQ, i[0], 24'h000600, SZ_WORD);
            if (b.HREADY === 1'b0) begin
                lows++;
                if (rd !== 1'b0 || wr !== 1'b0) bad++;
            end
        end
        chk("stall_no_strobe", bad, 0);
        chk("stall_ratio_ok", (lows > 350 && lows < 650), 1);
        stall_enable = 1'b0;
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        tick(); tick();
        #1;
        chk("stall_off_ready", b.HREADY, 1);

        // reset in the middle of a write burst
        drive(TR_NONSEQ, 1'b1, 24'h000700, SZ_WORD);
        tick();
        drive(TR_SEQ, 1'b1, 24'h000704, SZ_WORD);
        chk("rstmid_wr_before", wr, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(TR_IDLE, 1'b0, '0, SZ_WORD);
        chk("rstmid_wr_dropped", wr, 0);
        chk("rstmid_addr_wr", addr_wr, 0);
        chk("rstmid_hrdata", b.HRDATA, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
